mlp_layer_sched: RTL
====================

Name: mlp_layer_sched

Overview:
- Sequences the 5-layer MLP (784-64-32-32-16-10) over the shared processing unit.
- Per layer: streams input-vector and weight-row addresses to x_buf or temp_buf and to the selected w_buf, then drives the pu accumulator and ReLU controls.
- Writes layer outputs back to a ping-pong temp_buf; final-layer outputs go to y_buf.
- Sits between the global start/done interface and the buffers/pu, replacing per-layer glue in glbl_ctrl.

Parameters:
- N0, 784: layer-1 input length.
- N1..N5, 64/32/32/16/10: output lengths of layers 1..5 (layer k input = N(k-1)).
- ADDR_W, 10: read address width (holds N0-1).
- TMP_AW, 7: temp_buf address width; MSB = bank, low 6 bits = index.
- BRAM_LAT, 1: buffer read latency in cycles.
- PIPE_LAT, 2: drain cycles after last fetch before writeback.
- Y_ADDR_STEP, 4: y_buf byte-address stride.
- Y_AW, 6: y_buf address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- pu_ready_i  in  1  pu can accept data; low stalls FETCH.
- busy_o  out  1  high from FETCH entry until DONE.
- done_o  out  1  one-cycle completion pulse.
- layer_o  out  3  current layer, 0..4.
- x_buf_en_o  out  1  x_buf read enable (layer 0 only).
- w_buf_en_o  out  5  one-hot w_buf read enable, bit = layer.
- rd_addr_o  out  ADDR_W  shared input/weight row address = in_cnt.
- temp_rd_en_o  out  1  temp_buf read enable (layers 1..4).
- temp_rd_addr_o  out  TMP_AW  {rd_bank, in_cnt[5:0]}.
- in_sel_o  out  1  pu operand mux: 0 = x_buf, 1 = temp_buf.
- mac_valid_o  out  1  operand valid at pu (issue delayed BRAM_LAT).
- mac_clr_o  out  1  accumulator clear; coincident with first mac_valid_o of a layer.
- mac_last_o  out  1  coincident with last mac_valid_o of a layer.
- relu_en_o  out  1  high for layers 0..3, low for layer 4.
- wb_idx_o  out  6  neuron index being written back.
- temp_wr_en_o  out  1  temp_buf write strobe (layers 0..3 in WB).
- temp_wr_addr_o  out  TMP_AW  {wr_bank, wb_idx}.
- y_buf_en_o, y_buf_wr_en_o  out  1,1  y_buf strobes (layer 4 in WB).
- y_buf_addr_o  out  Y_AW  wb_idx*Y_ADDR_STEP.

Behaviour:
- Reset: state=IDLE, all counters/layer/bank=0, all outputs 0, including valid-delay pipes.
- States: IDLE, FETCH, DRAIN, WB, NEXT, DONE.
- IDLE -> FETCH on start_i. Enters with layer=0, in_cnt=0, rd_bank=0, wr_bank=1.
- FETCH:
  - Each cycle with pu_ready_i=1: assert the enable for the layer source (x_buf_en_o for layer 0, else temp_rd_en_o) plus w_buf_en_o[layer]; in_cnt++.
  - pu_ready_i=0: all enables low, counters hold.
  - After issuing in_cnt = N(layer)-1 -> DRAIN.
- mac_valid_o/clr/last are the issue strobes shifted by BRAM_LAT registers; no gaps are added beyond stalls.
- DRAIN: PIPE_LAT cycles, then WB with wb_idx=0.
- WB: one output per cycle, wb_idx 0..N(layer+1)-1.
  - Layers 0..3: temp_wr_en_o=1.
  - Layer 4: y_buf_en_o = y_buf_wr_en_o = 1; addresses 0, 4, ..., 36.
  - After the last index -> NEXT.
- NEXT (1 cycle): if layer=4 -> DONE; else layer++, swap rd_bank/wr_bank, in_cnt=0 -> FETCH.
  - Layer 1 reads bank 1; layer 2 reads bank 0; and so on.
- DONE (1 cycle): done_o=1, busy_o=0 -> IDLE.
- start_i ignored outside IDLE. No stalls during WB/DRAIN.
- Unstalled latency: start sampled at edge 0 -> done_o high in cycle 1 + 1097.
  - 1097 = sum of inputs 928 + sum of outputs 154 + 5*(PIPE_LAT+1).
- Reset mid-operation: immediate return to IDLE, no further writes. The next start runs a full fresh pass.
- Read and write never target the same temp bank in a layer.

Test Plan:
- Reset then start_i pulse, pu_ready_i=1 -> busy_o high cycles 1..1097; done_o single pulse at cycle 1098; exactly 10 y_buf writes at addresses 0..36 step 4.
- Layer 0 trace -> x_buf_en_o high for 784 cycles with rd_addr_o 0..783; mac_clr_o with first mac_valid_o; mac_last_o with the 784th; 64 temp writes to addresses 64..127 (bank 1).
- pu_ready_i low 3 cycles at in_cnt=100 of layer 2 -> no enables, address holds at 100; done_o delayed by exactly 3 cycles.
- start_i held high through the whole run -> a single pass only; a restart occurs only after return to IDLE.
- rst asserted mid-WB of layer 1 -> all outputs 0 the same cycle, state IDLE; a subsequent start gives the full 1097-cycle pass.
- relu_en_o/in_sel_o check -> in_sel_o=0 only in layer 0; relu_en_o=0 only in layer 4; w_buf_en_o one-hot matches layer_o.

Source files
------------

// File: rtl/mlp_layer_sched_if.sv
// Buffer / processing-unit side bus of the MLP layer scheduler.
// The scheduler drives it through the master modport.
// Buffers and the pu attach through the slave modport.
interface mlp_layer_sched_if #(
   parameter int ADDR_W = 10,
   parameter int TMP_AW = 7,
   parameter int Y_AW   = 6
);
   logic              pu_ready_i;
   logic              x_buf_en_o;
   logic [4:0]        w_buf_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic              temp_rd_en_o;
   logic [TMP_AW-1:0] temp_rd_addr_o;
   logic              in_sel_o;
   logic              mac_valid_o;
   logic              mac_clr_o;
   logic              mac_last_o;
   logic              relu_en_o;
   logic [5:0]        wb_idx_o;
   logic              temp_wr_en_o;
   logic [TMP_AW-1:0] temp_wr_addr_o;
   logic              y_buf_en_o;
   logic              y_buf_wr_en_o;
   logic [Y_AW-1:0]   y_buf_addr_o;

   modport master (
      input  pu_ready_i,
      output x_buf_en_o, w_buf_en_o, rd_addr_o, temp_rd_en_o, temp_rd_addr_o,
             in_sel_o, mac_valid_o, mac_clr_o, mac_last_o, relu_en_o, wb_idx_o,
             temp_wr_en_o, temp_wr_addr_o, y_buf_en_o, y_buf_wr_en_o, y_buf_addr_o
   );

   modport slave (
      output pu_ready_i,
      input  x_buf_en_o, w_buf_en_o, rd_addr_o, temp_rd_en_o, temp_rd_addr_o,
             in_sel_o, mac_valid_o, mac_clr_o, mac_last_o, relu_en_o, wb_idx_o,
             temp_wr_en_o, temp_wr_addr_o, y_buf_en_o, y_buf_wr_en_o, y_buf_addr_o
   );
endinterface

// File: rtl/mlp_layer_sched.sv
// Layer scheduler for the 784-64-32-32-16-10 MLP on the shared pu.
// Each layer runs through the same sequence:
//   1. Fetch the input and weight rows.
//   2. Drain the pu pipeline.
//   3. Write back one neuron per cycle.
// Layer outputs ping-pong between the two temp_buf banks. The last layer lands in y_buf.
module mlp_layer_sched #(
   parameter int N0          = 784,
   parameter int N1          = 64,
   parameter int N2          = 32,
   parameter int N3          = 32,
   parameter int N4          = 16,
   parameter int N5          = 10,
   parameter int ADDR_W      = 10,
   parameter int TMP_AW      = 7,
   parameter int BRAM_LAT    = 1,
   parameter int PIPE_LAT    = 2,
   parameter int Y_ADDR_STEP = 4,
   parameter int Y_AW        = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [2:0] layer_o,
   mlp_layer_sched_if.master bus
);
   localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DRAIN = 3'd2,
      S_WB    = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              r_state;
   logic [2:0]          r_layer;
   logic [ADDR_W-1:0]   r_in_cnt;
   logic [5:0]          r_wb_idx;
   logic [DRAIN_W-1:0]  r_drain_cnt;
   logic                r_rd_bank;
   logic                r_wr_bank;
   logic                r_busy;
   logic                r_done;
   logic                r_wb;
   logic [BRAM_LAT-1:0] r_vld_pipe;
   logic [BRAM_LAT-1:0] r_clr_pipe;
   logic [BRAM_LAT-1:0] r_last_pipe;

   logic w_issue;
   logic w_first_in;
   logic w_last_in;
   logic w_last_out;
   logic w_final;

   // Last input index of a layer (the layer's input length minus one).
   function automatic logic [ADDR_W-1:0] in_last(input logic [2:0] layer);
      case (layer)
         3'd0:    in_last = ADDR_W'(N0 - 1);
         3'd1:    in_last = ADDR_W'(N1 - 1);
         3'd2:    in_last = ADDR_W'(N2 - 1);
         3'd3:    in_last = ADDR_W'(N3 - 1);
         default: in_last = ADDR_W'(N4 - 1);
      endcase
   endfunction

   // Last output neuron index of a layer.
   function automatic logic [5:0] out_last(input logic [2:0] layer);
      case (layer)
         3'd0:    out_last = 6'(N1 - 1);
         3'd1:    out_last = 6'(N2 - 1);
         3'd2:    out_last = 6'(N3 - 1);
         3'd3:    out_last = 6'(N4 - 1);
         default: out_last = 6'(N5 - 1);
      endcase
   endfunction

   // A fetch is issued only while in FETCH and the pu accepts data.
   // The read enables therefore follow pu_ready_i within the same cycle.
   assign w_issue    = (r_state == S_FETCH) && bus.pu_ready_i;
   assign w_first_in = (r_in_cnt == ADDR_W'(0));
   assign w_last_in  = (r_in_cnt == in_last(r_layer));
   assign w_last_out = (r_wb_idx == out_last(r_layer));
   assign w_final    = (r_layer == 3'd4);

   // Main sequencer: state, counters, bank selects and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_layer     <= 3'd0;
         r_in_cnt    <= '0;
         r_wb_idx    <= 6'd0;
         r_drain_cnt <= '0;
         r_rd_bank   <= 1'b0;
         r_wr_bank   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wb        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state   <= S_FETCH;
                  r_layer   <= 3'd0;
                  r_in_cnt  <= '0;
                  r_rd_bank <= 1'b0;
                  r_wr_bank <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            S_FETCH: begin
               if (bus.pu_ready_i) begin
                  r_in_cnt <= r_in_cnt + ADDR_W'(1);
                  if (w_last_in) begin
                     r_state     <= S_DRAIN;
                     r_drain_cnt <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == DRAIN_W'(PIPE_LAT - 1)) begin
                  r_state  <= S_WB;
                  r_wb_idx <= 6'd0;
                  r_wb     <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
               end
            end
            S_WB: begin
               if (w_last_out) begin
                  r_state <= S_NEXT;
                  r_wb    <= 1'b0;
               end else begin
                  r_wb_idx <= r_wb_idx + 6'd1;
               end
            end
            S_NEXT: begin
               if (w_final) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state   <= S_FETCH;
                  r_layer   <= r_layer + 3'd1;
                  r_in_cnt  <= '0;
                  r_rd_bank <= r_wr_bank;
                  r_wr_bank <= r_rd_bank;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_wb    <= 1'b0;
            end
         endcase
      end
   end

   // Delay the issue strobes by the buffer read latency.
   // Valid, clear and last then line up with the operands at the pu.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_pipe  <= '0;
         r_clr_pipe  <= '0;
         r_last_pipe <= '0;
      end else begin
         r_vld_pipe[0]  <= w_issue;
         r_clr_pipe[0]  <= w_issue && w_first_in;
         r_last_pipe[0] <= w_issue && w_last_in;
         for (int i = 1; i < BRAM_LAT; i++) begin
            r_vld_pipe[i]  <= r_vld_pipe[i-1];
            r_clr_pipe[i]  <= r_clr_pipe[i-1];
            r_last_pipe[i] <= r_last_pipe[i-1];
         end
      end
   end

   assign busy_o  = r_busy;
   assign done_o  = r_done;
   assign layer_o = r_layer;

   assign bus.x_buf_en_o     = w_issue && (r_layer == 3'd0);
   assign bus.temp_rd_en_o   = w_issue && (r_layer != 3'd0);
   assign bus.w_buf_en_o     = w_issue ? (5'b00001 << r_layer) : 5'b00000;
   assign bus.rd_addr_o      = r_in_cnt;
   assign bus.temp_rd_addr_o = {r_rd_bank, r_in_cnt[TMP_AW-2:0]};
   assign bus.in_sel_o       = r_busy && (r_layer != 3'd0);
   assign bus.relu_en_o      = r_busy && !w_final;
   assign bus.mac_valid_o    = r_vld_pipe[BRAM_LAT-1];
   assign bus.mac_clr_o      = r_clr_pipe[BRAM_LAT-1];
   assign bus.mac_last_o     = r_last_pipe[BRAM_LAT-1];
   assign bus.wb_idx_o       = r_wb_idx;
   assign bus.temp_wr_en_o   = r_wb && !w_final;
   assign bus.temp_wr_addr_o = {r_wr_bank, r_wb_idx[TMP_AW-2:0]};
   assign bus.y_buf_en_o     = r_wb && w_final;
   assign bus.y_buf_wr_en_o  = r_wb && w_final;
   assign bus.y_buf_addr_o   = Y_AW'(int'(r_wb_idx) * Y_ADDR_STEP);
endmodule
